// File: rtl/present_dropper.sv
// present_dropper: drops a present at a random X, rests it on the floor with an end-of-life blink, reports collection
module present_dropper #(
  parameter int X_MIN = 0,
  parameter int X_MAX = 607,
  parameter int START_Y = 0,
  parameter int FLOOR_Y = 416,
  parameter int FALL_SPEED = 2,
  parameter int REST_FRAMES = 300,
  parameter int BLINK_FRAMES = 96,
  parameter int RAND_BITS = 10
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 startOfFrame,
  input  logic                 spawn,
  input  logic [RAND_BITS-1:0] randX,
  input  logic [2:0]           spawnType,
  input  logic                 collected,
  output logic [10:0]          topLeftX,
  output logic [10:0]          topLeftY,
  output logic                 presentActive,
  output logic                 presentVisible,
  output logic [2:0]           presentType,
  output logic                 presentTaken
);
  localparam int CW = $clog2(REST_FRAMES + 1);
  typedef enum logic [1:0] {IDLE, FALLING, RESTING} state_t;
  state_t state, state_nx;
  logic [10:0] x_nx, y_nx;
  logic [2:0] type_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic taken_nx;
  logic [11:0] rx, y_step;
  always_comb begin
    rx = 12'(randX);
    y_step = {1'b0, topLeftY} + 12'(FALL_SPEED);
    state_nx = state;
    x_nx = topLeftX;
    y_nx = topLeftY;
    type_nx = presentType;
    cnt_nx = cnt;
    taken_nx = 1'b0;
    case (state)
      IDLE: if (spawn) begin
        x_nx = rx > 12'(X_MAX) ? 11'(X_MAX) : rx < 12'(X_MIN) ? 11'(X_MIN) : rx[10:0];
        y_nx = 11'(START_Y);
        type_nx = spawnType;
        state_nx = FALLING;
      end
      FALLING: if (collected) begin
        taken_nx = 1'b1;
        state_nx = IDLE;
      end else if (startOfFrame) begin
        y_nx = y_step >= 12'(FLOOR_Y) ? 11'(FLOOR_Y) : y_step[10:0];
        cnt_nx = y_step >= 12'(FLOOR_Y) ? CW'(REST_FRAMES) : cnt;
        state_nx = y_step >= 12'(FLOOR_Y) ? RESTING : FALLING;
      end
      RESTING: if (collected) begin
        taken_nx = 1'b1;
        state_nx = IDLE;
      end else if (startOfFrame) begin
        cnt_nx = cnt - 1'b1;
        state_nx = cnt == CW'(1) ? IDLE : RESTING;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= IDLE;
      topLeftX <= '0;
      topLeftY <= '0;
      presentType <= '0;
      cnt <= '0;
      presentTaken <= 1'b0;
    end else begin
      state <= state_nx;
      topLeftX <= x_nx;
      topLeftY <= y_nx;
      presentType <= type_nx;
      cnt <= cnt_nx;
      presentTaken <= taken_nx;
    end
  end
  assign presentActive = state != IDLE;
  // bit 3 of the frame counter yields an 8-on / 8-off blink near expiry
  assign presentVisible = (state == RESTING && cnt <= CW'(BLINK_FRAMES)) ? cnt[3] : presentActive;
endmodule

// File: tb/tb_present_dropper.sv
// tb_present_dropper: directed checks of spawn, clamp, fall, rest/blink, collection and async reset
module tb_present_dropper;
  logic clk = 1'b0, resetN = 1'b0, sof = 1'b0, spawn = 1'b0, collected = 1'b0;
  logic [9:0] rand_x = '0;
  logic [2:0] spawn_type = '0;
  logic [10:0] x, y, x2, y2;
  logic active, visible, taken, active2, visible2, taken2;
  logic [2:0] ptype, ptype2;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  present_dropper dut (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .spawn(spawn), .randX(rand_x),
    .spawnType(spawn_type), .collected(collected), .topLeftX(x), .topLeftY(y),
    .presentActive(active), .presentVisible(visible), .presentType(ptype), .presentTaken(taken)
  );

  present_dropper #(.X_MIN(16)) dut2 (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .spawn(spawn), .randX(rand_x),
    .spawnType(spawn_type), .collected(collected), .topLeftX(x2), .topLeftY(y2),
    .presentActive(active2), .presentVisible(visible2), .presentType(ptype2), .presentTaken(taken2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      sof = 1'b1;
      tick();
      sof = 1'b0;
      tick();
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    tick();
    tick();
    chk("rst_x", 32'(x), 0);
    chk("rst_y", 32'(y), 0);
    chk("rst_type", 32'(ptype), 0);
    chk("rst_active", 32'(active), 0);
    chk("rst_visible", 32'(visible), 0);
    chk("rst_taken", 32'(taken), 0);
    resetN = 1'b1;
    tick();
    rand_x = 10'd200;
    spawn_type = 3'd5;
    spawn = 1'b1;
    tick();
    spawn = 1'b0;
    chk("spawn_x", 32'(x), 200);
    chk("spawn_x2", 32'(x2), 200);
    chk("spawn_y", 32'(y), 0);
    chk("spawn_active", 32'(active), 1);
    chk("spawn_visible", 32'(visible), 1);
    chk("spawn_type", 32'(ptype), 5);
    frames(207);
    chk("fall207_y", 32'(y), 414);
    chk("fall207_active", 32'(active), 1);
    tick();
    tick();
    tick();
    chk("no_sof_y", 32'(y), 414);
    frames(1);
    chk("floor_y", 32'(y), 416);
    chk("floor_visible", 32'(visible), 1);
    frames(203);
    chk("rest203_visible", 32'(visible), 1);
    frames(1);
    chk("blink96_visible", 32'(visible), 0);
    chk("blink96_active", 32'(active), 1);
    frames(1);
    chk("blink95_visible", 32'(visible), 1);
    frames(7);
    chk("blink88_visible", 32'(visible), 1);
    frames(1);
    chk("blink87_visible", 32'(visible), 0);
    frames(86);
    chk("rest299_active", 32'(active), 1);
    sof = 1'b1;
    tick();
    sof = 1'b0;
    chk("expire_active", 32'(active), 0);
    chk("expire_visible", 32'(visible), 0);
    chk("expire_taken", 32'(taken), 0);
    chk("expire_y_hold", 32'(y), 416);
    chk("expire_x_hold", 32'(x), 200);
    tick();
    chk("expire_taken_later", 32'(taken), 0);
    rand_x = 10'd1000;
    spawn = 1'b1;
    tick();
    spawn = 1'b0;
    chk("clamp_hi", 32'(x), 607);
    chk("clamp_hi2", 32'(x2), 607);
    collected = 1'b1;
    spawn = 1'b1;
    tick();
    collected = 1'b0;
    spawn = 1'b0;
    chk("collect_taken", 32'(taken), 1);
    chk("collect_active", 32'(active), 0);
    tick();
    chk("taken_one_cycle", 32'(taken), 0);
    chk("spawn_on_exit_ignored", 32'(active), 0);
    rand_x = 10'd3;
    spawn = 1'b1;
    tick();
    spawn = 1'b0;
    chk("clamp_lo_default", 32'(x), 3);
    chk("clamp_lo16", 32'(x2), 16);
    frames(50);
    chk("fall50_y", 32'(y), 100);
    rand_x = 10'd500;
    spawn_type = 3'd1;
    spawn = 1'b1;
    tick();
    spawn = 1'b0;
    chk("spawn_falling_x", 32'(x), 3);
    chk("spawn_falling_type", 32'(ptype), 5);
    collected = 1'b1;
    sof = 1'b1;
    tick();
    collected = 1'b0;
    sof = 1'b0;
    chk("midfall_taken", 32'(taken), 1);
    chk("midfall_type", 32'(ptype), 5);
    chk("midfall_y", 32'(y), 100);
    chk("midfall_active", 32'(active), 0);
    tick();
    chk("midfall_taken_end", 32'(taken), 0);
    rand_x = 10'd300;
    spawn_type = 3'd6;
    spawn = 1'b1;
    tick();
    spawn = 1'b0;
    frames(212);
    chk("rest2_y", 32'(y), 416);
    chk("rest2_active", 32'(active), 1);
    #2;
    resetN = 1'b0;
    #1;
    chk("areset_x", 32'(x), 0);
    chk("areset_y", 32'(y), 0);
    chk("areset_type", 32'(ptype), 0);
    chk("areset_active", 32'(active), 0);
    chk("areset_visible", 32'(visible), 0);
    tick();
    resetN = 1'b1;
    tick();
    chk("post_reset_idle", 32'(active), 0);
    rand_x = 10'd50;
    spawn_type = 3'd3;
    spawn = 1'b1;
    tick();
    spawn = 1'b0;
    chk("respawn_x", 32'(x), 50);
    chk("respawn_type", 32'(ptype), 3);
    chk("respawn_active", 32'(active), 1);
    frames(1);
    chk("respawn_fall_y", 32'(y), 2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
